// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl
// Run controller for an external LFSR and 11110 sequence detector.
// On an accepted start the seed is captured, the LFSR is loaded and the
// detector cleared. The LFSR is then stepped once per cycle until it returns
// to the seed, the step limit is reached, or the run is aborted. The period
// length and the detector hit count are reported at the end of the run.
//
// Ports
//   clk, reset    clock, asynchronous active-high reset
//   start         run request, sampled only in IDLE
//   abort         early end of a run, sampled only in RUN
//   seed          seed value, captured when start is accepted
//   lfsr_q        current LFSR register contents
//   det_hit       detector output for the current LFSR bit
//   lfsr_load     parallel load of lfsr_seed into the LFSR
//   lfsr_seed     captured seed
//   lfsr_en       advance the LFSR one step at this edge
//   det_rst       detector reset
//   busy          high in LOAD and RUN
//   done          one-cycle pulse when a run ends
//   period_found  run ended because lfsr_q returned to the seed
//   err           start accepted with an all-zero seed
//   step_count    LFSR steps taken in the last run
//   hit_count     detector hits in the last run (saturating)
module lfsr_seq_ctrl #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 16,
  parameter int MAX_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] lfsr_q,
  input  logic             det_hit,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_en,
  output logic             det_rst,
  output logic             busy,
  output logic             done,
  output logic             period_found,
  output logic             err,
  output logic [CNT_W-1:0] step_count,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] STEP_LIM = CNT_W'(MAX_CYC);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] seed_q,  seed_d;
  logic [CNT_W-1:0] step_q,  step_d;
  logic [CNT_W-1:0] hit_q,   hit_d;
  logic             pf_q,    pf_d;
  logic             err_q,   err_d;

  logic seed_match, at_limit, term;

  // step_q != 0 keeps the very first RUN cycle (LFSR still holding the seed)
  // from being taken as a completed period.
  assign seed_match = (step_q != '0) && (lfsr_q == seed_q);
  assign at_limit   = (step_q == STEP_LIM);
  assign term       = (state_q == S_RUN) && (abort || seed_match || at_limit);

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    step_d  = step_q;
    hit_d   = hit_q;
    pf_d    = pf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d = seed;
          step_d = '0;
          hit_d  = '0;
          pf_d   = 1'b0;
          // all-zero LFSR state locks up: report and skip the run entirely
          if (seed == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (term) begin
          state_d = S_DONE;
          pf_d    = !abort && seed_match;
        end else begin
          step_d = step_q + CNT_W'(1);
          if (det_hit && (hit_q != '1)) hit_d = hit_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      step_q  <= '0;
      hit_q   <= '0;
      pf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      step_q  <= step_d;
      hit_q   <= hit_d;
      pf_q    <= pf_d;
      err_q   <= err_d;
    end
  end

  assign lfsr_load    = (state_q == S_LOAD);
  assign det_rst      = (state_q == S_LOAD);
  assign lfsr_en      = (state_q == S_RUN) && !term;
  assign busy         = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done         = (state_q == S_DONE);
  assign lfsr_seed    = seed_q;
  assign period_found = pf_q;
  assign err          = err_q;
  assign step_count   = step_q;
  assign hit_count    = hit_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl. A small 4-bit LFSR model (x^4+x^3+1,
// period 15) follows the controller's load/enable; an alternate mode parks
// the model at 4'hF so it never returns to the seed. A second instance with
// MAX_CYC=10 covers the step limit.
module tb_lfsr_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, start_l = 1'b0, abort = 1'b0;
  logic [3:0] seed = 4'd0;
  logic       det_hit;
  logic       hmode = 1'b0, nonret = 1'b0, sel = 1'b0;
  logic [3:0] m_q = 4'd0;

  logic        ld, en, drst, busy, done, pf, err;
  logic [3:0]  lseed;
  logic [15:0] steps, hits;
  logic        ld_l, en_l, drst_l, busy_l, done_l, pf_l, err_l;
  logic [3:0]  lseed_l;
  logic [15:0] steps_l, hits_l;

  int n_cmp = 0, n_bad = 0;
  int en_cnt = 0, ld_cnt = 0, dn_cnt = 0, dnl_cnt = 0;
  int en0 = 0;

  always #5 clk = ~clk;

  lfsr_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .seed(seed),
    .lfsr_q(m_q), .det_hit(det_hit), .lfsr_load(ld), .lfsr_seed(lseed),
    .lfsr_en(en), .det_rst(drst), .busy(busy), .done(done),
    .period_found(pf), .err(err), .step_count(steps), .hit_count(hits)
  );

  lfsr_seq_ctrl #(.WIDTH(4), .CNT_W(16), .MAX_CYC(10)) dut_lim (
    .clk(clk), .reset(reset), .start(start_l), .abort(1'b0), .seed(seed),
    .lfsr_q(m_q), .det_hit(1'b0), .lfsr_load(ld_l), .lfsr_seed(lseed_l),
    .lfsr_en(en_l), .det_rst(drst_l), .busy(busy_l), .done(done_l),
    .period_found(pf_l), .err(err_l), .step_count(steps_l), .hit_count(hits_l)
  );

  // LFSR model driven by whichever controller is under test
  always @(posedge clk) begin
    if (sel ? ld_l : ld)       m_q <= sel ? lseed_l : lseed;
    else if (sel ? en_l : en)  m_q <= nonret ? 4'hF : {m_q[2:0], m_q[3] ^ m_q[0]};
  end

  // pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (en)     en_cnt  <= en_cnt + 1;
    if (ld)     ld_cnt  <= ld_cnt + 1;
    if (done)   dn_cnt  <= dn_cnt + 1;
    if (done_l) dnl_cnt <= dnl_cnt + 1;
  end

  // hit pattern: steps 4 and 9, plus the terminating RUN cycle
  always_comb begin
    det_hit = 1'b0;
    if (hmode)
      det_hit = (en && ((en_cnt - en0) == 4 || (en_cnt - en0) == 9)) ||
                (busy && !en && !ld);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // raise start for one edge; returns #1 after the accepting edge
  task automatic do_start(input bit lim, input logic [3:0] s);
    @(posedge clk); #1;
    seed = s;
    if (lim) start_l = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_l = 1'b0;
  endtask

  task automatic wait_done(input bit lim, output int cyc);
    bit seen = 0;
    cyc = 1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      cyc++;
      seen = lim ? done_l : done;
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      cyc = -1;
    end
  endtask

  initial begin
    int cyc, ld0, dn0;
    bit ok;

    // reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_seed", lseed, 0);
    chk("rst_steps", steps, 0);
    @(negedge clk); reset = 1'b0;

    // reset in the middle of a run
    do_start(0, 4'b0001);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (steps == 16'd5);
    end
    chk("mid_reach5", ok, 1);
    reset = 1'b1; #1;
    chk("mid_busy", busy, 0);
    chk("mid_en", en, 0);
    chk("mid_steps", steps, 0);
    chk("mid_seed", lseed, 0);
    @(posedge clk); #1; reset = 1'b0;

    // full period, no hits
    en0 = en_cnt;
    do_start(0, 4'b0001);
    chk("per_load", ld, 1);
    wait_done(0, cyc);
    chk("per_latency", cyc, 18);
    chk("per_steps", steps, 15);
    chk("per_pf", pf, 1);
    chk("per_hits", hits, 0);
    chk("per_en_pulses", en_cnt - en0, 15);

    // hits on steps 4 and 9 plus the terminating cycle
    @(posedge clk); #1;
    en0 = en_cnt; hmode = 1'b1;
    do_start(0, 4'b0001);
    wait_done(0, cyc);
    hmode = 1'b0;
    chk("hit_count", hits, 2);
    chk("hit_steps", steps, 15);

    // zero seed
    @(posedge clk); #1;
    ld0 = ld_cnt; en0 = en_cnt;
    do_start(0, 4'b0000);
    chk("z_done", done, 1);
    chk("z_err", err, 1);
    @(posedge clk); #1;
    chk("z_no_load", ld_cnt - ld0, 0);
    chk("z_no_en", en_cnt - en0, 0);
    do_start(0, 4'b1000);
    chk("z_err_clr", err, 0);
    wait_done(0, cyc);
    chk("z2_steps", steps, 15);
    chk("z2_pf", pf, 1);

    // abort after 7 steps with start pulses during RUN
    @(posedge clk); #1;
    dn0 = dn_cnt;
    do_start(0, 4'b0001);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clk); #1;
      start = (steps == 16'd3) || (steps == 16'd6);
      ok = (steps == 16'd7);
    end
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab_done", done, 1);
    chk("ab_steps", steps, 7);
    chk("ab_pf", pf, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("ab_busy", busy, 0);
    chk("ab_one_done", dn_cnt - dn0, 1);

    // step limit, LFSR never returns to the seed
    sel = 1'b1; nonret = 1'b1;
    dn0 = dnl_cnt;
    do_start(1, 4'b0001);
    wait_done(1, cyc);
    chk("lim_steps", steps_l, 10);
    chk("lim_pf", pf_l, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("lim_one_done", dnl_cnt - dn0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Run controller for the LFSR and the 11110 sequence detector. On a start request it loads a seed into the LFSR and clears the detector. It then steps the LFSR one bit per cycle, counting steps and detector hits, until the LFSR returns to its seed, a step limit is reached, or the run is aborted. It sits above the LFSR and detector and reports period length and hit count to the top-level status logic.

## Interface
- WIDTH, 4: LFSR register width.
- CNT_W, 16: width of the step and hit counters.
- MAX_CYC, 1000: step limit per run; must be at most 2**CNT_W-1.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  ends a run early; sampled only in RUN.
- seed  in  WIDTH  seed value; captured when start is accepted.
- lfsr_q  in  WIDTH  current LFSR register contents.
- det_hit  in  1  detector output for the current LFSR bit.
- lfsr_load  out  1  parallel load of lfsr_seed into the LFSR.
- lfsr_seed  out  WIDTH  captured seed.
- lfsr_en  out  1  advances the LFSR one step at this edge.
- det_rst  out  1  reset to the sequence detector.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse when a run ends.
- period_found  out  1  the run ended because lfsr_q equalled the seed.
- err  out  1  start was accepted with seed == 0.
- step_count  out  CNT_W  number of LFSR steps in the last run.
- hit_count  out  CNT_W  number of detector hits in the last run; saturates at all-ones.

## Operation
- States are IDLE, LOAD, RUN and DONE. Reset forces IDLE.
- Reset values: all outputs 0, seed register 0, counters 0.
- IDLE:
  - start=1 with seed!=0: capture seed, clear step_count, hit_count, period_found and err; go to LOAD.
  - start=1 with seed==0: set err=1 and go to DONE. The all-zero LFSR state locks up, so no load or step happens.
- LOAD (1 cycle): lfsr_load=1 and det_rst=1; go to RUN.
- RUN: a combinational term signal is computed each cycle, with this priority:
  - abort=1 ends the run.
  - Otherwise, step_count!=0 and lfsr_q==lfsr_seed ends the run and sets period_found=1 at the transition edge.
  - Otherwise, step_count==MAX_CYC ends the run.
- lfsr_en = (state==RUN) && !term. Only when lfsr_en=1 does step_count increment and det_hit add 1 to hit_count.
- When term=1, go to DONE. No step is taken and no hit is counted in that cycle.
- DONE (1 cycle): done=1, then go to IDLE.
- step_count, hit_count, period_found and err hold their values until the next accepted start.
- start while busy and abort outside RUN are ignored. start and abort in the same cycle are resolved by state.
- Reset during any state: immediate return to IDLE with all outputs 0. The detector reset is driven again on the next LOAD.

## Timing
- Start accepted at edge E0. LOAD occupies the cycle after E0 and RUN begins one edge later, so the first lfsr_en=1 cycle is 2 cycles after start.
- Run with period P: exactly P cycles with lfsr_en=1, then 1 terminating RUN cycle, then 1 DONE cycle. done goes high P+3 cycles after the start edge, and step_count=P at that point.
- A step-limit run gives step_count=MAX_CYC.
- Abort sampled in RUN: done is high on the following cycle.
- lfsr_load, det_rst, lfsr_en, busy and done are decoded from the state register. term is the only combinational dependence on lfsr_q and abort.
- Counters are valid when done is high.

## Test plan
- Reset mid-RUN after 5 steps -> next cycle: busy=0, lfsr_en=0, counters 0, state IDLE; a new start works normally.
- Bench LFSR model with period 15 (x^4+x^3+1), seed 4'b0001, det_hit tied 0 -> done 18 cycles after start; step_count=15, period_found=1, hit_count=0, exactly 15 lfsr_en pulses.
- Same seed, det_hit forced high on steps 4 and 9 and also high in the terminating cycle -> hit_count=2.
- MAX_CYC=10, bench LFSR that never returns to the seed -> step_count=10, period_found=0, done once.
- seed=0 with start -> err=1, done on the next cycle, no lfsr_load or lfsr_en pulse; a following start with seed=4'b1000 clears err.
- Abort asserted after 7 steps, plus start pulses during RUN -> step_count=7, period_found=0, a single done pulse, and the start pulses are ignored.
